// File: rtl/cc_ctrl_pkg.sv
// Shared types, defaults and cycle-conversion helper for the CC line attach controller.
package cc_ctrl_pkg;

    localparam int CNT_W         = 24;
    localparam int GUARD_CYC_DEF = 4;

    typedef enum logic [2:0] {
        ST_DETACHED,
        ST_DEBOUNCE,
        ST_ATTACHED,
        ST_GUARD,
        ST_TX
    } cc_state_t;

    function automatic int us_to_cyc(input int khz, input int us);
        return (khz * us) / 1000;
    endfunction

endpackage

// File: rtl/cc_idle_det.sv
// Received-data synchronizer, edge detect and saturating idle counter.
// bus_idle_raw is the look-ahead "counter will be at its limit" flag for registering upstream.
module cc_idle_det
    import cc_ctrl_pkg::*;
#(
    parameter int IDLE_CYC = 25
) (
    input  logic clock,
    input  logic nrst,
    input  logic din,
    input  logic clr,
    output logic bus_idle_raw
);

    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYC);

    logic             din_m;
    logic             din_s;
    logic             din_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clock) begin
        if (!nrst) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_d <= 1'b0;
            cnt   <= '0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_d <= din_s;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (clr || (din_s ^ din_d)) begin
            cnt_nxt = '0;
        end else if (cnt != IDLE_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    assign bus_idle_raw = (cnt_nxt == IDLE_MAX);

endmodule

// File: rtl/cc_attach_ctrl.sv
// CC line sequencing: debounced attach/detach with orientation strobe, bus-idle detect, half-duplex TX arbitration.
// Defining CC_TX_TIMEOUT_EN adds a TX watchdog that aborts a grant held too long.
module cc_attach_ctrl
    import cc_ctrl_pkg::*;
#(
    parameter int system_khz  = 200000,
    parameter int DEBOUNCE_US = 100,
    parameter int IDLE_US     = 25,
    parameter int GUARD_CYC   = GUARD_CYC_DEF,
    parameter int TX_MAX_US   = 2000
) (
    input  logic clock,
    input  logic nrst,
    input  logic cc_lock,
    input  logic cc_din,
    output logic cc_check,
    output logic cc_io_ctrl,
    output logic attached,
    output logic detach_evt,
    output logic bus_idle,
    input  logic tx_req,
    output logic tx_gnt,
    input  logic tx_done,
    output logic tx_abort
);

    localparam int DEB_CYC   = us_to_cyc(system_khz, DEBOUNCE_US);
    localparam int IDLE_CYC  = us_to_cyc(system_khz, IDLE_US);
    localparam int TXMAX_CYC = us_to_cyc(system_khz, TX_MAX_US);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

    if (DEB_CYC < 1 || IDLE_CYC < 1 || GUARD_CYC < 1 || TXMAX_CYC < 1 ||
        DEB_CYC >= (1 << CNT_W) || IDLE_CYC >= (1 << CNT_W) ||
        GUARD_CYC >= (1 << CNT_W) || TXMAX_CYC >= (1 << CNT_W)) begin : g_cfg_err
        $error("cc_attach_ctrl: derived cycle counts must lie in 1 .. 2**CNT_W-1");
    end

    logic             lock_m;
    logic             lock_s;
    cc_state_t        state;
    cc_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             idle_raw;
    logic             idle_clr;
    logic             tx_allow;

    logic             cc_check_d;
    logic             cc_io_ctrl_d;
    logic             attached_d;
    logic             detach_evt_d;
    logic             bus_idle_d;
    logic             tx_gnt_d;

`ifdef CC_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TXMAX_CYC - 1);
    logic             wd_abort;
    logic             tx_block;
`endif

    // The PHY's own drive disturbs the received stream, so idle timing restarts once TX ends.
    assign idle_clr = (state == ST_GUARD) || (state == ST_TX);

    cc_idle_det #(
        .IDLE_CYC     (IDLE_CYC)
    ) u_idle_det (
        .clock        (clock),
        .nrst         (nrst),
        .din          (cc_din),
        .clr          (idle_clr),
        .bus_idle_raw (idle_raw)
    );

    always_ff @(posedge clock) begin
        if (!nrst) begin
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            state      <= ST_DETACHED;
            cnt        <= '0;
            cc_check   <= 1'b0;
            cc_io_ctrl <= 1'b0;
            attached   <= 1'b0;
            detach_evt <= 1'b0;
            bus_idle   <= 1'b0;
            tx_gnt     <= 1'b0;
        end else begin
            lock_m     <= cc_lock;
            lock_s     <= lock_m;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cc_check   <= cc_check_d;
            cc_io_ctrl <= cc_io_ctrl_d;
            attached   <= attached_d;
            detach_evt <= detach_evt_d;
            bus_idle   <= bus_idle_d;
            tx_gnt     <= tx_gnt_d;
        end
    end

    // One counter serves debounce, lock-loss, guard and watchdog; it restarts at every state change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
`ifdef CC_TX_TIMEOUT_EN
        wd_abort  = 1'b0;
`endif
        case (state)
            ST_DETACHED: begin
                if (lock_s) state_nxt = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!lock_s)              state_nxt = ST_DETACHED;
                else if (cnt == DEB_LAST) state_nxt = ST_ATTACHED;
                else                      cnt_nxt   = cnt + CNT_W'(1);
            end
            ST_ATTACHED: begin
                if (!lock_s && cnt == DEB_LAST)         state_nxt = ST_DETACHED;
                else if (tx_req && bus_idle && tx_allow) state_nxt = ST_GUARD;
                else if (!lock_s)                        cnt_nxt   = cnt + CNT_W'(1);
            end
            ST_GUARD: begin
                if (!tx_req)                state_nxt = ST_ATTACHED;
                else if (cnt == GUARD_LAST) state_nxt = ST_TX;
                else                        cnt_nxt   = cnt + CNT_W'(1);
            end
            ST_TX: begin
                if (tx_done || !tx_req) state_nxt = ST_ATTACHED;
`ifdef CC_TX_TIMEOUT_EN
                else if (cnt == TX_LAST) begin
                    state_nxt = ST_ATTACHED;
                    wd_abort  = 1'b1;
                end
                else cnt_nxt = cnt + CNT_W'(1);
`endif
            end
            default: state_nxt = ST_DETACHED;
        endcase
    end

    always_comb begin
        attached_d   = (state_nxt == ST_ATTACHED) || (state_nxt == ST_GUARD) || (state_nxt == ST_TX);
        cc_check_d   = (state == ST_DEBOUNCE) && (state_nxt == ST_ATTACHED);
        detach_evt_d = (state == ST_ATTACHED) && (state_nxt == ST_DETACHED);
        cc_io_ctrl_d = (state_nxt == ST_GUARD) || (state_nxt == ST_TX);
        tx_gnt_d     = (state_nxt == ST_TX);
        bus_idle_d   = idle_raw && (state_nxt == ST_ATTACHED);
    end

`ifdef CC_TX_TIMEOUT_EN
    // After an abort the requester has to let go of tx_req before it can win the line again.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            tx_abort <= 1'b0;
            tx_block <= 1'b0;
        end else begin
            tx_abort <= wd_abort;
            if (wd_abort)     tx_block <= 1'b1;
            else if (!tx_req) tx_block <= 1'b0;
        end
    end
    assign tx_allow = !tx_block;
`else
    assign tx_abort = 1'b0;
    assign tx_allow = 1'b1;
`endif

endmodule
